// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-SRAM responder: word geometry, address helper, clear FSM states.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package cpu_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Byte address to word address; the caller keeps only the low ADDR_W bits,
    // which is what makes out-of-range addresses wrap onto the array.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dsram_rd_pipe.sv
// Read-result delay line: valid+data shift register, DEPTH stages, no bypass.
// Latency: output appears exactly DEPTH rising edges after the capturing edge.
// Backpressure: none; accepts one entry per cycle, data of the last valid entry is held.
module dsram_rd_pipe
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [WORD_W-1:0] in_dat,
    output logic              out_vld,
    output logic [WORD_W-1:0] out_dat
);

    logic              vld_q [DEPTH];
    logic [WORD_W-1:0] dat_q [DEPTH];

    // Stage 0 captures on a valid access and otherwise holds its data; later stages just shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                dat_q[0] <= in_dat;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM model: word array with byte-lane writes, read-before-write, results RD_LAT cycles later.
// Latency: rvalid/rdata exactly RD_LAT edges after an en=1 edge; optional clear (DSRAM_RESET_CLEAR_EN) adds 2**ADDR_W cycles after reset.
// Backpressure: none; one access per cycle; with DSRAM_RESET_CLEAR_EN, accesses during the clear are dropped.
module data_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          RD_LAT   = 1,
    parameter logic [31:0] INIT_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_en,
    input  logic [LANES-1:0]  data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [WORD_W-1:0] data_sram_wdata,
    output logic [WORD_W-1:0] data_sram_rdata,
`ifdef DSRAM_RESET_CLEAR_EN
    output logic              data_sram_ready,
`endif
    output logic              data_sram_rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $fatal(1, "data_sram_responder: RD_LAT must be in 1..4");
        end
    endgenerate

    logic [WORD_W-1:0] mem [DEPTH];
    logic [29:0]       waddr;
    logic [ADDR_W-1:0] idx;
    logic [WORD_W-1:0] rd_word;
    logic              acc;

    assign waddr   = word_addr(data_sram_addr);
    assign idx     = waddr[ADDR_W-1:0];
    // Combinational read of the pre-edge contents gives read-before-write for free.
    assign rd_word = mem[idx];

`ifdef DSRAM_RESET_CLEAR_EN
    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we;
    logic              unused_addr;

    assign unused_addr     = ^waddr[29:ADDR_W];
    assign acc             = data_sram_en && (state_q == READY);
    assign data_sram_ready = (state_q == READY);

    // Clear FSM state and word counter; reset restarts the sweep from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one word per cycle; leave CLEAR after the last word has been written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Array writes: the clear sweep owns the array until READY, then byte-lane writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (acc) begin
            for (int b = 0; b < LANES; b++) begin
                if (data_sram_wen[b]) begin
                    mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits = (^waddr[29:ADDR_W]) ^ (^INIT_VAL);
    assign acc         = data_sram_en;

    // Array writes: only enabled byte lanes of the addressed word change; array is never reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int b = 0; b < LANES; b++) begin
                if (data_sram_wen[b]) begin
                    mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end
`endif

    dsram_rd_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (acc),
        .in_dat  (rd_word),
        .out_vld (data_sram_rvalid),
        .out_dat (data_sram_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: random and directed accesses against an array model.
// Latency: expected results are due RD_LAT edges after each accepted request.
// Backpressure: none; the bench may issue one access per cycle.
module tb_data_sram_responder;

`ifdef DSRAM_RESET_CLEAR_EN
    localparam int          AW       = 4;
    localparam logic [31:0] INIT     = 32'h5A5A5A5A;
    localparam int          CLR_CYCS = 1 << AW;
`else
    localparam int          AW       = 10;
    localparam logic [31:0] INIT     = 32'h0;
    localparam int          CLR_CYCS = 0;
`endif
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 3;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        en     = 1'b0;
    logic [3:0]  wen    = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic        rvalid;
`ifdef DSRAM_RESET_CLEAR_EN
    logic        ready;
`endif

    always #5 clk = ~clk;

    data_sram_responder #(
        .ADDR_W   (AW),
        .RD_LAT   (LAT),
        .INIT_VAL (INIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .data_sram_en     (en),
        .data_sram_wen    (wen),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata),
`ifdef DSRAM_RESET_CLEAR_EN
        .data_sram_ready  (ready),
`endif
        .data_sram_rvalid (rvalid)
    );

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_dat   = 32'h0;
    int          cyc        = 0;
    int          clear_left = CLR_CYCS;
    int          n_cmp      = 0;
    int          n_bad      = 0;
    bit          done       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Edge counter and the bench's own view of how much of the clear sweep remains.
    always @(posedge clk) begin
        cyc++;
        if (!reset && clear_left > 0) clear_left--;
    end

    // Monitor: every cycle, the output must match exactly what the scoreboard says is due.
    always @(negedge clk) begin
        if (!done) begin
            if (reset) begin
                chk("rvalid_in_reset", {31'b0, rvalid}, 32'h0);
                chk("rdata_in_reset", rdata, 32'h0);
            end else begin
                bit due_now;
                due_now = (q.size() > 0) && (q[0].due == cyc);
                chk("rvalid", {31'b0, rvalid}, {31'b0, due_now});
                if (due_now) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", rdata, e.dat);
                    last_dat = e.dat;
                end else begin
                    chk("rdata_hold", rdata, last_dat);
                end
                while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
            end
`ifdef DSRAM_RESET_CLEAR_EN
            chk("ready", {31'b0, ready}, {31'b0, (!reset && clear_left == 0)});
`endif
        end
    end

    // One cycle of stimulus; the request edge is the next rising edge.
    task automatic access(input bit e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input bit use_exp = 1'b0,
                          input logic [31:0] exp_d = 32'h0);
        int i;
        i = int'((a >> 2) % DEPTH);
        @(negedge clk);
        en = e; wen = w; addr = a; wdata = d;
        if (e && clear_left == 0) begin
            q.push_back('{cyc + LAT, use_exp ? exp_d : model[i]});
            for (int b = 0; b < 4; b++)
                if (w[b]) model[i][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic wait_clear();
        for (int k = 0; k < 4 * DEPTH && clear_left > 0; k++) access(1'b0, 4'h0, 32'h0, 32'h0);
        if (clear_left > 0) chk("clear_timeout", clear_left, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
        repeat (3) @(negedge clk);
        reset = 1'b0;

`ifdef DSRAM_RESET_CLEAR_EN
        // A write during the clear must be dropped; then every word reads back INIT.
        access(1'b1, 4'hF, 32'h8, 32'h12345678);
        wait_clear();
        for (int i = 0; i < DEPTH; i++) access(1'b1, 4'h0, i * 4, 32'h0, 1'b1, 32'h5A5A5A5A);
`else
        for (int i = 0; i < DEPTH; i++) access(1'b1, 4'hF, i * 4, $urandom);
`endif

        // Byte merge.
        access(1'b1, 4'hF, 32'h10, 32'h11223344);
        access(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD);
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 32'h11BB33DD);
        access(1'b0, 4'h0, 32'h0, 32'h0);

        // Read-before-write, then write-then-read.
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        access(1'b1, 4'hF, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 32'h0);

        // Aliasing of high and low address bits.
        access(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
        access(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
        access(1'b1, 4'h0, 32'h3, 32'h0, 1'b1, 32'hCAFEF00D);

        // Streaming back-to-back, then with random idle gaps.
        for (int i = 0; i < 8; i++) access(1'b1, 4'h0, 32'h40 + i * 4, 32'h0);
        for (int i = 0; i < 8; i++) access(1'($urandom_range(0, 1)), 4'h0, 32'h40 + i * 4, 32'h0);

        // Random mix: full-width addresses exercise aliasing, partial byte enables exercise merging.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            access(($urandom_range(0, 9) < 7), w, $urandom, $urandom);
        end

        // Reset mid-flight, asserted between clock edges.
        access(1'b1, 4'hF, 32'h20, 32'h0BADCAFE);
        access(1'b1, 4'h0, 32'h20, 32'h0);
        access(1'b1, 4'h0, 32'h24, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        en = 1'b0;
        q.delete();
        last_dat = 32'h0;
        clear_left = CLR_CYCS;
`ifdef DSRAM_RESET_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
`endif
        #1;
        chk("rvalid_at_async_reset", {31'b0, rvalid}, 32'h0);
        chk("rdata_at_async_reset", rdata, 32'h0);
        repeat (2) @(negedge clk);
        #3;
        reset = 1'b0;
        wait_clear();
        for (int k = 0; k < LAT + 2; k++) access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b1, 4'h0, 32'h20, 32'h0);
        for (int i = 0; i < 40; i++) access(($urandom_range(0, 1) == 1), 4'h0, $urandom, 32'h0);

        // Drain outstanding results within a bounded number of cycles.
        for (int k = 0; k < LAT + 5 && q.size() > 0; k++) access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        chk("undelivered_results", q.size(), 32'h0);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder/model for the data-SRAM interface driven by the memory stage: accepts en/wen/addr/wdata and returns read data after a fixed, parameterised latency.
- Holds a word-addressed storage array with per-byte write enables.
- Sits on the far side of the data_sram_* bus: a simulation/FPGA memory for the 5-stage CPU and the target for memory-stage verification.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words of 32 bits.
- RD_LAT, 1, read latency in cycles, legal range 1..4. 1 matches the pipeline's synchronous SRAM timing.
- INIT_VAL, 32'h0, value written to every word by the optional clear feature.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i].
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data.
- data_sram_rvalid  out  1  rdata holds the result of the access issued RD_LAT cycles earlier.

Behaviour:
- Reset, asserted asynchronously: rdata=0, rvalid=0, all latency-pipeline valid bits cleared. The storage array is NOT cleared; its contents are preserved.
- Word index = addr[ADDR_W+1:2]. addr[1:0] and addr[31:ADDR_W+2] are ignored, so out-of-range addresses alias (wrap modulo depth).
- Access occurs on a rising edge with en=1. en=0 means no access: wen, addr and wdata are ignored and no pipeline valid is injected.
- Write (en=1, wen!=0): at the edge, each enabled byte lane of mem[idx] takes the corresponding wdata byte. Disabled lanes are unchanged.
- Read data: every en=1 access, reads included, captures the pre-edge value of mem[idx] (read-before-write).
  - A same-cycle write to the same word returns the old value.
  - A write in cycle N followed by a read in cycle N+1 returns the new value.
- Latency pipeline: a stage-0 register captures {1, mem[idx]} on an en=1 edge and {0, hold data} otherwise. It feeds RD_LAT-1 further register stages, with no bypass.
  - rvalid/rdata appear exactly RD_LAT edges after the request edge.
  - Back-to-back accesses every cycle are supported: one result per cycle, in order, with no stalls.
- On rvalid=0 cycles, rdata holds its last valid value and does not return to 0.
- Reset mid-operation: in-flight results are discarded and rvalid=0 from the reset edge. After reset deasserts, the first rvalid occurs RD_LAT edges after the first en=1 edge. Writes that completed before reset persist.
- RD_LAT outside 1..4 is a configuration error and must trigger a fatal elaboration/simulation-time check.

Optional Feature:
- Macro DSRAM_RESET_CLEAR_EN.
- Defined:
  - A 2-state FSM is added: CLEAR → READY.
  - Reset forces CLEAR with clear counter = 0. Each cycle writes INIT_VAL to mem[counter] and increments the counter. After word 2**ADDR_W-1 the FSM moves to READY.
  - An extra output data_sram_ready (1 bit) is 0 in CLEAR and 1 in READY.
  - Requests with en=1 during CLEAR are ignored: no write, no rvalid.
  - The clear takes 2**ADDR_W cycles.
  - Reset during CLEAR restarts the clear from word 0.
- Undefined: no FSM, no data_sram_ready port, and array contents after reset are unchanged.

Decomposition:
- Shared package (cpu_mem_pkg): the word width 32, byte-lane count 4, the word-index extraction helper, and the FSM state enum {CLEAR, READY} used by the optional feature.
- One natural sub-module, dsram_rd_pipe: a parameterised RD_LAT-deep valid+data shift register with async reset. The top holds the array, the byte-merge write and the optional clear FSM.

Test Plan:
- Byte merge: write 0x11223344 with wen=4'hF to addr 0x10, then write 0xAABBCCDD with wen=4'b0101 to the same address, then read addr 0x10 → rdata=0x11BB33DD, rvalid pulses exactly RD_LAT cycles after the read edge.
- Read-before-write: mem[4]=0xDEADBEEF, then one cycle with en=1, wen=4'hF, wdata=0x0, addr=0x10 → rdata=0xDEADBEEF. A read of 0x10 on the next cycle → 0x00000000.
- Aliasing: with ADDR_W=10, write 0xCAFEF00D to addr 0x1000, read addr 0x0000 and addr 0x0003 → both return 0xCAFEF00D.
- Streaming: with RD_LAT=3, read 8 consecutive words every cycle → rvalid high for 8 consecutive cycles starting 3 cycles after the first request, data in order. en=0 cycles inserted between reads produce rvalid gaps in the same positions.
- Reset mid-flight: with RD_LAT=4, issue 2 reads, then assert reset asynchronously (not clock-aligned) → rvalid=0 immediately and no stale result appears after release. A previously written word still reads back correctly.
- DSRAM_RESET_CLEAR_EN with ADDR_W=4 and INIT_VAL=0x5A5A5A5A:
  - data_sram_ready=0 for 16 cycles after reset release, then 1.
  - A write attempted during CLEAR has no effect.
  - All 16 words read back 0x5A5A5A5A.
